// File: rtl/memi_pkg.sv
// Shared instruction-memory definitions: default capacity, loader state
// encoding and the big-endian byte-lane positions used by both the loader
// (write side) and the instruction fetch (read side).
package memi_pkg;

  localparam int MEM_DEPTH_DEF = 1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } ld_state_t;

  // Byte lane k of a word sits at [LANEk_LSB +: LANE_W]; lane 0 is the MSB
  // so that memory byte address order matches big-endian word order.
  localparam int LANE_W    = 8;
  localparam int LANE0_LSB = 24;
  localparam int LANE1_LSB = 16;
  localparam int LANE2_LSB = 8;
  localparam int LANE3_LSB = 0;

endpackage

// File: rtl/ins_loader_if.sv
// Instruction word stream into the loader: valid/ready handshake carrying a
// 32-bit word and an end-of-session marker.
interface ins_loader_if;

  logic        WVALID;
  logic [31:0] WDATA;
  logic        WLAST;
  logic        WREADY;

  modport master (output WVALID, output WDATA, output WLAST, input WREADY);
  modport slave  (input WVALID, input WDATA, input WLAST, output WREADY);

endinterface

// File: rtl/ins_loader.sv
// Instruction memory loader: accepts 32-bit words and writes them as four
// big-endian bytes at consecutive addresses starting at BASE. Words that
// would run past the end of memory are dropped and flag ERR.
// Optional feature: define INS_LOADER_CHECKSUM_EN to add the CHK output
// (mod-256 sum of the bytes written in the current session).
module ins_loader
  import memi_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int AW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          START,
  input  logic [AW-1:0] BASE,
  ins_loader_if.slave   w,
  output logic          MWE,
  output logic [AW-1:0] MADDR,
  output logic [7:0]    MDATA,
  output logic          DONE,
  output logic          ERR,
  output logic          BUSY
`ifdef INS_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]    CHK
`endif
);

  ld_state_t     state;
  logic [AW-1:0] ptr;
  logic [1:0]    idx;
  logic [31:0]   word;
  logic          last;
  logic          wready_q;

  logic [1:0]    nxt_idx;
  logic [7:0]    nxt_byte;
  logic [AW:0]   end_addr;
  logic          ovf;

  assign w.WREADY = wready_q;

  // Word overflows when its last byte would land beyond MEM_DEPTH-1; one extra
  // bit keeps the sum from wrapping for BASE values near the top of AW.
  assign end_addr = {1'b0, ptr} + (AW+1)'(3);
  assign ovf      = end_addr > (AW+1)'(MEM_DEPTH - 1);

  // Byte lane for the next WRITE cycle, big-endian lane order.
  always_comb begin
    nxt_idx  = idx + 2'd1;
    nxt_byte = 8'h00;
    case (nxt_idx)
      2'd0: nxt_byte = word[LANE0_LSB +: LANE_W];
      2'd1: nxt_byte = word[LANE1_LSB +: LANE_W];
      2'd2: nxt_byte = word[LANE2_LSB +: LANE_W];
      2'd3: nxt_byte = word[LANE3_LSB +: LANE_W];
      default: nxt_byte = 8'h00;
    endcase
  end

  // Session FSM; all outputs are registered and set alongside the transition
  // into the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      word     <= '0;
      last     <= 1'b0;
      wready_q <= 1'b0;
      MWE      <= 1'b0;
      MADDR    <= '0;
      MDATA    <= '0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            ptr      <= BASE;
            ERR      <= 1'b0;
            BUSY     <= 1'b1;
            wready_q <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (w.WVALID) begin
            wready_q <= 1'b0;
            if (ovf) begin
              // Drop the word entirely and close the session.
              ERR   <= 1'b1;
              DONE  <= 1'b1;
              state <= FINISH;
            end else begin
              word  <= w.WDATA;
              last  <= w.WLAST;
              idx   <= 2'd0;
              MWE   <= 1'b1;
              MADDR <= ptr;
              MDATA <= w.WDATA[LANE0_LSB +: LANE_W];
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          ptr <= ptr + AW'(1);
          idx <= nxt_idx;
          if (idx == 2'd3) begin
            MWE   <= 1'b0;
            MADDR <= '0;
            MDATA <= '0;
            if (last) begin
              DONE  <= 1'b1;
              state <= FINISH;
            end else begin
              wready_q <= 1'b1;
              state    <= WAIT;
            end
          end else begin
            MADDR <= ptr + AW'(1);
            MDATA <= nxt_byte;
          end
        end
        FINISH: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INS_LOADER_CHECKSUM_EN
  // Running byte sum; the last byte lands on the edge into FINISH so CHK is
  // settled while DONE is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CHK <= '0;
    end else if (state == IDLE && START) begin
      CHK <= '0;
    end else if (MWE) begin
      CHK <= CHK + MDATA;
    end
  end
`endif

endmodule

// File: tb/tb_ins_loader.sv
// Directed bench for ins_loader: expected byte writes are queued as words are
// offered and retired by a negedge monitor that also models the memory.
module tb_ins_loader;

  localparam int MEM_DEPTH = 1000;
  localparam int AW        = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          START = 1'b0;
  logic [AW-1:0] BASE = '0;
  logic          MWE;
  logic [AW-1:0] MADDR;
  logic [7:0]    MDATA;
  logic          DONE, ERR, BUSY;
`ifdef INS_LOADER_CHECKSUM_EN
  logic [7:0]    CHK;
`endif

  ins_loader_if wif ();

  ins_loader #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .START(START), .BASE(BASE), .w(wif),
    .MWE(MWE), .MADDR(MADDR), .MDATA(MDATA),
    .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
`ifdef INS_LOADER_CHECKSUM_EN
    , .CHK(CHK)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t sb[$];
  logic [7:0] mem [0:1023];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_mwe = 0;
  int last_mwe = 0;
  logic mwe_prev = 1'b0;
  logic [31:0] exp_ptr = 0;
  logic [7:0]  exp_chk = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // Retire byte writes against the scoreboard and track handshake rules.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (MWE) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexp_mwe: observed addr=%0h expected no write", MADDR);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("waddr", 64'(MADDR), 64'(e.a));
        check("wdata", 64'(MDATA), 64'(e.d));
      end
      if (MADDR < 1024) mem[MADDR[9:0]] = MDATA;
      if (!mwe_prev) first_mwe = cyc;
      last_mwe = cyc;
    end
    mwe_prev = MWE;
    if (wif.WREADY) check("wready_only_wait", {61'd0, MWE, DONE, BUSY}, 64'b001);
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start(input logic [31:0] b);
    @(posedge clk); #1;
    START = 1'b1; BASE = b;
    @(posedge clk); #1;
    START = 1'b0; BASE = '0;
    exp_ptr = b;
    exp_chk = 8'h00;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input int gap);
    bit acc = 0;
    repeat (gap) @(posedge clk);
    #1;
    if (exp_ptr + 3 <= MEM_DEPTH - 1) begin
      for (int k = 0; k < 4; k++) begin
        exp_t e;
        e.a = exp_ptr + k;
        e.d = d[31-8*k -: 8];
        sb.push_back(e);
        exp_chk = exp_chk + e.d;
      end
      exp_ptr = exp_ptr + 4;
    end
    wif.WVALID = 1'b1; wif.WDATA = d; wif.WLAST = l;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      if (wif.WREADY) begin
        @(posedge clk); #1;
        acc = 1;
      end
    end
    wif.WVALID = 1'b0; wif.WDATA = '0; wif.WLAST = 1'b0;
    check("accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (DONE) seen = 1;
    end
    check("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(DONE), 64'd0);
  endtask

  initial begin
    int d0;
    bit hit;
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit hit;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    wif.WVALID = 1'b0; wif.WDATA = '0; wif.WLAST = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {wif.WREADY, MWE, MADDR, MDATA, DONE, ERR, BUSY}, 64'd0);
    rst = 1'b0;

    // Single word at 0, read back big-endian.
    d0 = done_cnt;
    start(0);
    check("busy_wait", {62'd0, BUSY, wif.WREADY}, 64'b11);
    send(32'h8C220004, 1'b1, 0);
    wait_done();
    check("w0_readback", 64'(rd(0)), 64'h8C220004);
    check("w0_consec", 64'(last_mwe - first_mwe), 64'd3);
    check("w0_done_after", 64'(done_cyc - last_mwe), 64'd1);
    check("w0_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("w0_idle", {62'd0, BUSY, ERR}, 64'd0);
    check("w0_sb_empty", 64'(sb.size()), 64'd0);
`ifdef INS_LOADER_CHECKSUM_EN
    check("w0_chk", 64'(CHK), 64'(exp_chk));
`endif

    // Three words with gaps at 8.
    d0 = done_cnt;
    start(8);
    send(32'hDEADBEEF, 1'b0, 2);
    send(32'h01234567, 1'b0, 2);
    send(32'hA5C3F00F, 1'b1, 2);
    wait_done();
    check("m_rd8", 64'(rd(8)), 64'hDEADBEEF);
    check("m_rd12", 64'(rd(12)), 64'h01234567);
    check("m_rd16", 64'(rd(16)), 64'hA5C3F00F);
    check("m_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("m_sb_empty", 64'(sb.size()), 64'd0);

    // Fill to the end of memory, then overflow.
    d0 = done_cnt;
    start(996);
    send(32'h11223344, 1'b0, 0);
    send(32'hAABBCCDD, 1'b1, 1);
    wait_done();
    check("ovf_rd996", 64'(rd(996)), 64'h11223344);
    check("ovf_err", 64'(ERR), 64'd1);
    check("ovf_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("ovf_sb_empty", 64'(sb.size()), 64'd0);

    // START during WAIT is ignored; ERR clears on new session.
    start(100);
    check("err_cleared", 64'(ERR), 64'd0);
    @(posedge clk); #1;
    START = 1'b1; BASE = 500;
    @(posedge clk); #1;
    START = 1'b0; BASE = '0;
    send(32'h5A5AC3C3, 1'b1, 0);
    wait_done();
    check("ign_rd100", 64'(rd(100)), 64'h5A5AC3C3);
    check("ign_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of a word.
    start(200);
    send(32'hCAFEF00D, 1'b1, 0);
    hit = 0;
    for (int t = 0; t < 20 && !hit; t++) begin
      @(negedge clk);
      if (MWE && MADDR == 202) hit = 1;
    end
    check("mid_reached", 64'(hit), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_outs", {wif.WREADY, MWE, MADDR, MDATA, DONE, ERR, BUSY}, 64'd0);
    check("mid_left", 64'(sb.size()), 64'd1);
    sb.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_quiet", {62'd0, MWE, BUSY}, 64'd0);
    start(300);
    send(32'h01020304, 1'b1, 0);
    for (int t = 0; t < 20 && !DONE; t++) @(negedge clk);
    check("rs_done", 64'(DONE), 64'd1);
`ifdef INS_LOADER_CHECKSUM_EN
    check("rs_chk", 64'(CHK), 64'h0A);
`endif
    @(negedge clk);
    check("rs_rd300", 64'(rd(300)), 64'h01020304);
    check("rs_sb_empty", 64'(sb.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ins_loader.md
INS_LOADER -- requirements
Module: ins_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1000, meaning byte capacity of the target instruction memory.
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port START  input  1  begin a load session at BASE.
REQ-006 SHALL have port BASE  input  AW  first byte address of the session.
REQ-007 SHALL have port WVALID  input  1  instruction word offered.
REQ-008 SHALL have port WDATA  input  32  instruction word.
REQ-009 SHALL have port WLAST  input  1  offered word is the final one of the session.
REQ-010 SHALL have port WREADY  output  1  word accepted this cycle when WVALID=1.
REQ-011 SHALL have ports MWE output 1, MADDR output AW, MDATA output 8: byte write port to the instruction memory.
REQ-012 SHALL have ports DONE output 1 (one-cycle pulse at session end), ERR output 1 (sticky overflow flag), BUSY output 1.

Function
REQ-013 SHALL implement states IDLE, WAIT, WRITE, FINISH.
REQ-014 IDLE: BUSY=0, WREADY=0; START=1 latches BASE into pointer PTR, clears ERR, next state WAIT.
REQ-015 WAIT: WREADY=1; on WVALID=1 latch WDATA and WLAST, byte index IDX=0, next state WRITE; WVALID=0 holds WAIT indefinitely.
REQ-016 WRITE: MWE=1, MADDR=PTR, MDATA=word byte IDX big-endian (IDX0=[31:24], IDX1=[23:16], IDX2=[15:8], IDX3=[7:0]); PTR and IDX increment each cycle.
REQ-017 After IDX=3: latched WLAST=1 -> FINISH, else -> WAIT; throughput one word per 5 cycles minimum.
REQ-018 FINISH: DONE=1 for exactly one cycle, then IDLE.
REQ-019 Overflow: on acceptance, if PTR+3 > MEM_DEPTH-1, word SHALL be dropped (no MWE), ERR set to 1, next state FINISH regardless of WLAST.
REQ-020 START SHALL be ignored in any state other than IDLE; BUSY=1 in WAIT, WRITE, FINISH.
REQ-021 MWE SHALL be 0 outside WRITE; MADDR/MDATA don't-care when MWE=0 but SHALL be held at 0.
REQ-022 PTR arithmetic SHALL be AW-bit unsigned; wrap-around impossible because of REQ-019 check.

Reset
REQ-023 rst=1 SHALL force IDLE, PTR=0, IDX=0, WREADY=0, MWE=0, MADDR=0, MDATA=0, DONE=0, ERR=0, BUSY=0 immediately, including mid-WRITE (partial word abandoned, no further writes).

Configuration
REQ-024 With macro INS_LOADER_CHECKSUM_EN defined, SHALL add output CHK (8 bits) = modulo-256 sum of all bytes written this session, cleared on START and reset, valid when DONE=1.
REQ-025 Without INS_LOADER_CHECKSUM_EN, CHK port and its adder SHALL be absent.

Structure
REQ-026 Shared package memi_pkg SHALL hold MEM_DEPTH default, state enumeration, and byte-lane select constants shared with the instruction-memory read side.
REQ-027 Single module, no sub-module; byte-lane mux inline.

Verification
REQ-028 START, BASE=0, one word 0x8C220004 WLAST=1 -> writes mem[0..3]=0x8C,0x22,0x00,0x04 on 4 consecutive cycles, DONE pulse next cycle; readback via read side yields 0x8C220004.
REQ-029 BASE=8, three words, WVALID gaps of 2 cycles -> addresses 8..19 written in order, WREADY only in WAIT, single DONE.
REQ-030 BASE=996, word 0x11223344 -> writes 996..999 OK; second word at 1000 -> no MWE, ERR=1, DONE pulse.
REQ-031 rst asserted during WRITE at IDX=2 -> MWE drops immediately, all outputs 0, IDLE; new START works normally.
REQ-032 START pulsed during WAIT -> ignored, PTR unchanged.
REQ-033 With INS_LOADER_CHECKSUM_EN: word 0x01020304 -> CHK=0x0A at DONE.
